// File: rtl/count_capture.sv
// ----------------------------------------------------------------------------
// count_capture
//   Timestamp capture stage behind the free-running counter. The live count is
//   sampled on a rising edge of event_in, or when count first equals cmp_value
//   while compares are enabled. Each sample is tagged with its source and
//   pushed into a small show-ahead FIFO. The consumer drains it through a
//   valid/ready port. A capture that finds the FIFO full, with no pop on the
//   same edge, is dropped and raises a sticky overflow flag. The FIFO never
//   back-pressures the counter.
//
// Ports
//   clk        : clock, rising edge (same clock as the counter)
//   reset_n    : asynchronous active-low reset
//   count      : live counter value
//   event_in   : event level; a capture fires on its rising edge
//   cmp_en     : enables compare capture
//   cmp_value  : compare target
//   cap_data   : head-of-FIFO timestamp (0 when empty)
//   cap_src    : head source, bit0 = event, bit1 = compare (0 when empty)
//   cap_valid  : FIFO non-empty
//   cap_ready  : consumer accepts the head entry
//   level      : occupancy, 0..DEPTH
//   overflow   : sticky drop flag
//   clear_ovf  : clears overflow (a drop on the same edge wins)
// ----------------------------------------------------------------------------
module count_capture #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [WIDTH-1:0]           count,
   input  logic                       event_in,
   input  logic                       cmp_en,
   input  logic [WIDTH-1:0]           cmp_value,
   output logic [WIDTH-1:0]           cap_data,
   output logic [1:0]                 cap_src,
   output logic                       cap_valid,
   input  logic                       cap_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [1:0]       src;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     lvl;
   logic              event_d, match_d;

   logic              match, ev_hit, cmp_hit;
   logic              wr, pop, full, wr_ok, drop;
   entry_t            head;

   // Edge detection: both history registers reset to 0, so a level already
   // high when reset is released counts as a fresh edge.
   assign match   = cmp_en & (count == cmp_value);
   assign ev_hit  = event_in & ~event_d;
   assign cmp_hit = match & ~match_d;

   assign wr    = ev_hit | cmp_hit;
   assign pop   = cap_valid & cap_ready;
   assign full  = (lvl == LW'(DEPTH));
   // When full, wr_ptr == rd_ptr; a same-edge pop frees exactly the slot the
   // write lands in, and the head has already been presented combinationally.
   assign wr_ok = wr & (~full | pop);
   assign drop  = wr & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_d <= 1'b0;
         match_d <= 1'b0;
      end else begin
         event_d <= event_in;
         match_d <= match;
      end
   end

   // Storage needs no reset: every read is gated by cap_valid.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= '{src: {cmp_hit, ev_hit}, data: count};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop})
            2'b10:   lvl <= lvl + LW'(1);
            2'b01:   lvl <= lvl - LW'(1);
            default: lvl <= lvl;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       overflow <= 1'b0;
      else if (drop)      overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
   end

   always_comb begin
      head = mem[rd_ptr];
      if (!cap_valid) head = '0;
   end

   assign cap_valid = (lvl != '0);
   assign cap_data  = head.data;
   assign cap_src   = head.src;
   assign level     = lvl;

endmodule

// File: tb/tb_count_capture.sv
module tb_count_capture;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] count;
   logic             event_in;
   logic             cmp_en;
   logic [WIDTH-1:0] cmp_value;
   logic [WIDTH-1:0] cap_data;
   logic [1:0]       cap_src;
   logic             cap_valid;
   logic             cap_ready;
   logic [2:0]       level;
   logic             overflow;
   logic             clear_ovf;

   int vecs = 0;
   int errs = 0;

   count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .count(count), .event_in(event_in),
      .cmp_en(cmp_en), .cmp_value(cmp_value), .cap_data(cap_data),
      .cap_src(cap_src), .cap_valid(cap_valid), .cap_ready(cap_ready),
      .level(level), .overflow(overflow), .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [31:0] d, input logic [1:0] s);
      chk({tag, ".valid"}, 64'(cap_valid), 64'd1);
      chk({tag, ".data"},  64'(cap_data),  64'(d));
      chk({tag, ".src"},   64'(cap_src),   64'(s));
   endtask

   task automatic empty(input string tag);
      chk({tag, ".valid"}, 64'(cap_valid), 64'd0);
      chk({tag, ".level"}, 64'(level),     64'd0);
      chk({tag, ".data"},  64'(cap_data),  64'd0);
      chk({tag, ".src"},   64'(cap_src),   64'd0);
   endtask

   // Rise event_in at count c (one cycle high, one low).
   task automatic ev_pulse(input int c);
      count = 32'(c); event_in = 1'b1; tick();
      count = 32'(c + 1); event_in = 1'b0; tick();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; event_in = 1'b1; count = 32'd0; cmp_en = 1'b0;
      cmp_value = '0; cap_ready = 1'b0; clear_ovf = 1'b0;

      // Reset with event_in held high
      #3;
      empty("rst_async");
      chk("rst_async.ovf", 64'(overflow), 64'd0);
      tick(); tick();
      empty("rst_held");
      count = 32'd100;
      reset_n = 1'b1;
      tick();
      head("rst_rel", 32'd100, 2'b01);
      chk("rst_rel.level", 64'(level), 64'd1);
      count = 32'd101; tick();
      chk("rst_hold.level", 64'(level), 64'd1);
      event_in = 1'b0; cap_ready = 1'b1; tick();
      empty("rst_pop");
      cap_ready = 1'b0;

      // Event capture: pulse at 5, held high 9..11
      for (int c = 0; c < 15; c++) begin
         count = 32'(c);
         event_in = (c == 5) || (c >= 9 && c <= 11);
         tick();
      end
      chk("ev.level", 64'(level), 64'd2);
      head("ev.h0", 32'd5, 2'b01);
      cap_ready = 1'b1; tick();
      head("ev.h1", 32'd9, 2'b01);
      chk("ev.level1", 64'(level), 64'd1);
      tick();
      empty("ev.drained");
      cap_ready = 1'b0;

      // Compare: counter stalled at 7
      cmp_en = 1'b1; cmp_value = 32'd7; count = 32'd7;
      repeat (4) tick();
      chk("cmp.level", 64'(level), 64'd1);
      head("cmp.h", 32'd7, 2'b10);
      count = 32'd8; cap_ready = 1'b1; tick();
      empty("cmp.pop");
      cap_ready = 1'b0; count = 32'd6; tick();
      count = 32'd7; event_in = 1'b1; tick();
      event_in = 1'b0; repeat (3) tick();
      chk("both.level", 64'(level), 64'd1);
      head("both.h", 32'd7, 2'b11);
      count = 32'd8; cmp_en = 1'b0; cap_ready = 1'b1; tick();
      empty("both.pop");
      cap_ready = 1'b0;

      // Fill and overflow: rises at 1,3,5,7,9
      for (int c = 1; c <= 10; c++) begin
         count = 32'(c); event_in = c[0]; tick();
      end
      chk("fill.level", 64'(level), 64'd4);
      chk("fill.ovf",   64'(overflow), 64'd1);
      cap_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         head("fill.drain", 32'(1 + 2 * k), 2'b01);
         tick();
      end
      empty("fill.empty");
      chk("fill.ovf_sticky", 64'(overflow), 64'd1);
      cap_ready = 1'b0;
      clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
      chk("clr.ovf", 64'(overflow), 64'd0);

      // Full with simultaneous pop
      ev_pulse(12); ev_pulse(14); ev_pulse(16); ev_pulse(18);
      chk("full.level", 64'(level), 64'd4);
      count = 32'd20; event_in = 1'b1; cap_ready = 1'b1; tick();
      cap_ready = 1'b0; event_in = 1'b0; count = 32'd21; tick();
      chk("fullpop.level", 64'(level), 64'd4);
      chk("fullpop.ovf",   64'(overflow), 64'd0);
      head("fullpop.h", 32'd14, 2'b01);
      ev_pulse(22);
      chk("drop.ovf",   64'(overflow), 64'd1);
      chk("drop.level", 64'(level), 64'd4);
      count = 32'd24; event_in = 1'b1; clear_ovf = 1'b1; tick();
      event_in = 1'b0; clear_ovf = 1'b0; count = 32'd25; tick();
      chk("clrdrop.ovf", 64'(overflow), 64'd1);
      cap_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         head("fullpop.drain", 32'(14 + 2 * k), 2'b01);
         tick();
      end
      empty("fullpop.empty");
      cap_ready = 1'b0;

      // Mid-run reset between edges
      ev_pulse(30); ev_pulse(32); ev_pulse(34);
      chk("mid.level", 64'(level), 64'd3);
      #2 reset_n = 1'b0;
      #1;
      empty("mid.rst");
      chk("mid.ovf", 64'(overflow), 64'd0);
      tick();
      reset_n = 1'b1; tick();
      chk("mid.idle", 64'(level), 64'd0);
      ev_pulse(40);
      head("mid.resume", 32'd40, 2'b01);
      chk("mid.resume.level", 64'(level), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
